// File: rtl/mig_eval_sched_pkg.sv
// Shared types and constants for the MIG evaluation scheduler.
// Operand select codes: 0 = const 0, 1..7 = x0..x6, 8+k = result of gate k.
package mig_pkg;

  localparam int NIN       = 7;
  localparam int OP_CONST0 = 0;
  localparam int OP_X_BASE = 1;
  localparam int OP_G_BASE = 8;

  typedef struct packed {
    logic       inv;
    logic [4:0] sel;
  } operand_t;

  // Operand A occupies the low six bits of a gate word.
  typedef struct packed {
    operand_t c;
    operand_t b;
    operand_t a;
  } gate_word_t;

  typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/mig_eval_sched_if.sv
// Host-side bundle for the MIG evaluator: program port, run controls and results.
interface mig_eval_sched_if #(
  parameter int MAX_GATES = 16
);
  localparam int AW = $clog2(MAX_GATES);

  logic                    prog_we;
  logic [AW-1:0]           prog_addr;
  logic [17:0]             prog_data;
  logic [AW:0]             num_gates;
  logic                    out_inv;
  logic                    mode;
  logic [mig_pkg::NIN-1:0] x_in;
  logic                    start;
  logic                    busy;
  logic                    done;
  logic                    err;
  logic                    out_bit;
  logic [127:0]            tt;

  modport master (
    output prog_we, prog_addr, prog_data, num_gates, out_inv, mode, x_in, start,
    input  busy, done, err, out_bit, tt
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, num_gates, out_inv, mode, x_in, start,
    output busy, done, err, out_bit, tt
  );

endinterface

// File: rtl/mig_eval_sched_gate_unit.sv
// Combinational majority unit: resolves three operands against x and earlier gate
// results, and flags any operand that points at gate g or beyond.
module mig_gate_unit
  import mig_pkg::*;
#(
  parameter int MAX_GATES = 16,
  localparam int AW = $clog2(MAX_GATES)
) (
  input  gate_word_t           word,
  input  logic [NIN-1:0]       x,
  input  logic [MAX_GATES-1:0] r,
  input  logic [AW-1:0]        g,
  output logic                 result,
  output logic                 illegal
);

  logic [1:0] ea, eb, ec;

  // Returns {illegal, value}; since g never exceeds MAX_GATES-1, the g bound also
  // rejects selects past the last gate.
  function automatic logic [1:0] eval_op(input operand_t op, input logic [NIN-1:0] xv,
                                         input logic [MAX_GATES-1:0] rv, input logic [AW-1:0] gv);
    logic [4:0] idx;
    logic       v;
    logic       bad;
    idx = op.sel - 5'(OP_G_BASE);
    v   = 1'b0;
    bad = 1'b0;
    if (op.sel == 5'(OP_CONST0))
      v = 1'b0;
    else if (op.sel < 5'(OP_G_BASE))
      v = xv[op.sel[2:0] - 3'(OP_X_BASE)];
    else if (6'(idx) >= 6'(gv))
      bad = 1'b1;
    else
      v = rv[idx[AW-1:0]];
    return {bad, v ^ op.inv};
  endfunction

  assign ea = eval_op(word.a, x, r, g);
  assign eb = eval_op(word.b, x, r, g);
  assign ec = eval_op(word.c, x, r, g);

  assign result  = maj3(ea[0], eb[0], ec[0]);
  assign illegal = ea[1] | eb[1] | ec[1];

endmodule

// File: rtl/mig_eval_sched.sv
// MIG evaluator top: gate-list storage, per-gate result registers and the run FSM
// that steps one gate per cycle over a single vector or all 128 vectors.
module mig_eval_sched
  import mig_pkg::*;
#(
  parameter int MAX_GATES = 16
) (
  input logic              clk,
  input logic              rst_n,
  mig_eval_sched_if.slave  bus
);

  localparam int AW = $clog2(MAX_GATES);
  localparam int GW = AW + 1;

  state_t               state, state_d;
  gate_word_t           prog [MAX_GATES];
  logic [MAX_GATES-1:0] r;
  logic [AW-1:0]        g;
  logic [GW-1:0]        gcount;
  logic                 inv_q;
  logic                 mode_q;
  logic [NIN-1:0]       x;
  logic [127:0]         tt_q;
  logic                 out_bit_q;
  logic                 err_q;
  logic                 accept;
  logic                 start_err;
  logic                 last;
  logic                 gate_res;
  logic                 gate_bad;

  mig_gate_unit #(.MAX_GATES(MAX_GATES)) u_gate (
    .word    (prog[g]),
    .x       (x),
    .r       (r),
    .g       (g),
    .result  (gate_res),
    .illegal (gate_bad)
  );

  always_comb begin
    state_d   = state;
    accept    = 1'b0;
    start_err = 1'b0;
    last      = ({1'b0, g} == gcount - GW'(1));
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          start_err = (bus.num_gates == '0) || (bus.num_gates > GW'(MAX_GATES));
          state_d   = start_err ? DONE : EVAL;
        end
      end
      EVAL: begin
        if (gate_bad || (last && (!mode_q || x == '1)))
          state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_d;
  end

  // An aborting gate writes nothing, so results from completed vectors stay intact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_GATES; i++)
        prog[i] <= '0;
      r         <= '0;
      g         <= '0;
      gcount    <= '0;
      inv_q     <= 1'b0;
      mode_q    <= 1'b0;
      x         <= '0;
      tt_q      <= '0;
      out_bit_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (state == IDLE && bus.prog_we)
        prog[bus.prog_addr] <= gate_word_t'(bus.prog_data);
      if (accept) begin
        gcount <= bus.num_gates;
        inv_q  <= bus.out_inv;
        mode_q <= bus.mode;
        x      <= bus.mode ? '0 : bus.x_in;
        g      <= '0;
        err_q  <= start_err;
      end
      if (state == EVAL) begin
        if (gate_bad) begin
          err_q <= 1'b1;
        end else begin
          r[g] <= gate_res;
          if (!last) begin
            g <= g + AW'(1);
          end else if (!mode_q) begin
            out_bit_q <= gate_res ^ inv_q;
          end else begin
            tt_q[x] <= gate_res ^ inv_q;
            if (x != '1) begin
              x <= x + NIN'(1);
              g <= '0;
            end
          end
        end
      end
    end
  end

  assign bus.busy    = (state != IDLE);
  assign bus.done    = (state == DONE);
  assign bus.err     = err_q;
  assign bus.out_bit = out_bit_q;
  assign bus.tt      = tt_q;

endmodule

// File: tb/tb_mig_eval_sched.sv
// Directed and randomized bench for mig_eval_sched against a gate-list reference
// model that evaluates the program vector by vector with plain arithmetic.
module tb_mig_eval_sched;

  localparam int MAXG = 16;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  mig_eval_sched_if #(.MAX_GATES(MAXG)) bus ();

  mig_eval_sched #(.MAX_GATES(MAXG)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int           errors = 0;
  int           checks = 0;
  logic [17:0]  prog_m [MAXG];
  logic [127:0] model_tt;
  logic         model_bit;
  logic         exp_err;
  int           exp_lat;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  task automatic progWrite(input int addr, input logic [17:0] data);
    @(negedge clk);
    bus.prog_we   = 1'b1;
    bus.prog_addr = 4'(addr);
    bus.prog_data = data;
    @(negedge clk);
    bus.prog_we = 1'b0;
    prog_m[addr] = data;
  endtask

  // Evaluates the shadow program; done offset is G+1 / 128G+1, or k+2 on an abort at gate k.
  function automatic void modelRun(input logic mode, input logic [6:0] xv, input int gn, input logic inv);
    logic res [MAXG];
    int   lo, hi;
    exp_err = 1'b0;
    if (gn == 0 || gn > MAXG) begin
      exp_err = 1'b1;
      exp_lat = 1;
      return;
    end
    exp_lat = mode ? 128 * gn + 1 : gn + 1;
    lo = mode ? 0 : int'(xv);
    hi = mode ? 127 : int'(xv);
    for (int v = lo; v <= hi; v++) begin
      for (int k = 0; k < gn; k++) begin
        int ones;
        ones = 0;
        for (int i = 0; i < 3; i++) begin
          int   sel;
          logic val;
          sel = int'(prog_m[k][6*i +: 5]);
          if (sel == 0)
            val = 1'b0;
          else if (sel < 8)
            val = 1'((v >> (sel - 1)) & 1);
          else if (sel - 8 >= k) begin
            exp_err = 1'b1;
            exp_lat = k + 2;
            return;
          end else
            val = res[sel - 8];
          if ((val ^ prog_m[k][6*i + 5]) == 1'b1)
            ones++;
        end
        res[k] = (ones >= 2);
      end
      if (mode)
        model_tt[v] = res[gn-1] ^ inv;
      else
        model_bit = res[gn-1] ^ inv;
    end
  endfunction

  task automatic applyStimulus(input string tag, input logic mode, input logic [6:0] xv,
                               input int gn, input logic inv, input bit disturb);
    int cyc;
    bit busy_ok;
    modelRun(mode, xv, gn, inv);
    @(negedge clk);
    bus.mode      = mode;
    bus.x_in      = xv;
    bus.num_gates = 5'(gn);
    bus.out_inv   = inv;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cyc       = 1;
    busy_ok   = 1'b1;
    while (bus.done !== 1'b1 && cyc < 128 * MAXG + 8) begin
      busy_ok       = busy_ok & (bus.busy === 1'b1);
      bus.start     = disturb && cyc == 3;
      bus.prog_we   = disturb && cyc == 3;
      bus.prog_addr = 4'($urandom_range(0, MAXG - 1));
      bus.prog_data = 18'($urandom);
      @(negedge clk);
      cyc++;
    end
    bus.start   = 1'b0;
    bus.prog_we = 1'b0;
    checkOutput({tag, "_latency"}, 128'(cyc), 128'(exp_lat));
    checkOutput({tag, "_busy"}, 128'(busy_ok & (bus.busy === 1'b1)), 128'(1));
    checkOutput({tag, "_err"}, 128'(bus.err), 128'(exp_err));
    checkOutput({tag, "_out_bit"}, 128'(bus.out_bit), 128'(model_bit));
    checkOutput({tag, "_tt"}, bus.tt, model_tt);
    @(negedge clk);
    checkOutput({tag, "_idle_after"}, 128'({bus.done, bus.busy}), 128'(0));
  endtask

  task automatic randProg(input int gn);
    logic [17:0] w;
    for (int k = 0; k < gn; k++) begin
      for (int i = 0; i < 3; i++) begin
        int rr;
        rr = int'($urandom_range(0, 199));
        if (rr == 199)
          w[6*i +: 5] = 5'(8 + $urandom_range(k, MAXG - 1));
        else if (rr >= 100 && k > 0)
          w[6*i +: 5] = 5'(8 + $urandom_range(0, k - 1));
        else
          w[6*i +: 5] = 5'($urandom_range(0, 7));
        w[6*i + 5] = 1'($urandom_range(0, 1));
      end
      progWrite(k, w);
    end
  endtask

  initial begin
    bus.prog_we   = 1'b0;
    bus.prog_addr = '0;
    bus.prog_data = '0;
    bus.num_gates = '0;
    bus.out_inv   = 1'b0;
    bus.mode      = 1'b0;
    bus.x_in      = '0;
    bus.start     = 1'b0;
    for (int i = 0; i < MAXG; i++)
      prog_m[i] = '0;
    model_tt  = '0;
    model_bit = 1'b0;
    rst_n     = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset_busy", 128'(bus.busy), 128'(0));
    checkOutput("reset_done", 128'(bus.done), 128'(0));
    checkOutput("reset_err", 128'(bus.err), 128'(0));
    checkOutput("reset_out_bit", 128'(bus.out_bit), 128'(0));
    checkOutput("reset_tt", bus.tt, 128'(0));

    progWrite(0, {6'd3, 6'd2, 6'd1});
    applyStimulus("maj3", 1'b1, 7'd0, 1, 1'b0, 1'b0);
    checkOutput("maj3_table", bus.tt, {16{8'hE8}});

    progWrite(0, {6'd0, 6'd2, 6'd1});
    applyStimulus("and_inv", 1'b1, 7'd0, 1, 1'b1, 1'b0);
    checkOutput("and_inv_table", bus.tt, {32{4'h7}});
    applyStimulus("and", 1'b1, 7'd0, 1, 1'b0, 1'b0);
    checkOutput("and_table", bus.tt, {32{4'h8}});

    progWrite(0, {6'd2, 6'd33, 6'd1});
    progWrite(1, {6'd0, 6'd3, 6'd8});
    applyStimulus("two_gate_hi", 1'b0, 7'b0000110, 2, 1'b0, 1'b0);
    checkOutput("two_gate_hi_const", 128'(bus.out_bit), 128'(1));
    applyStimulus("two_gate_lo", 1'b0, 7'b0000100, 2, 1'b0, 1'b0);
    checkOutput("two_gate_lo_const", 128'(bus.out_bit), 128'(0));

    progWrite(0, {6'd0, 6'd0, 6'd9});
    applyStimulus("fwd_ref", 1'b0, 7'b0000110, 2, 1'b0, 1'b0);
    applyStimulus("zero_gates", 1'b0, 7'd5, 0, 1'b0, 1'b0);
    applyStimulus("too_many", 1'b1, 7'd0, MAXG + 1, 1'b0, 1'b0);

    // Disturbing writes and starts during the sweep must leave the program intact.
    for (int k = 0; k < 6; k++)
      progWrite(k, {6'd0, 6'(k + 1), 6'((k == 0) ? 3 : 8 + k - 1)});
    applyStimulus("busy_disturb", 1'b1, 7'd0, 6, 1'b1, 1'b1);
    applyStimulus("busy_rerun", 1'b1, 7'd0, 6, 1'b1, 1'b0);

    for (int t = 0; t < 8; t++) begin
      int gn;
      gn = int'($urandom_range(1, MAXG));
      randProg(gn);
      applyStimulus("rand_single", 1'b0, 7'($urandom), gn, 1'($urandom), 1'b0);
      if (t < 3)
        applyStimulus("rand_sweep", 1'b1, 7'($urandom), gn, 1'($urandom), 1'b0);
    end

    progWrite(0, {6'd3, 6'd2, 6'd1});
    @(negedge clk);
    bus.mode      = 1'b1;
    bus.num_gates = 5'd1;
    bus.out_inv   = 1'b0;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (40) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_tt", bus.tt, 128'(0));
    checkOutput("midrst_busy", 128'(bus.busy), 128'(0));
    checkOutput("midrst_flags", 128'({bus.done, bus.err, bus.out_bit}), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < MAXG; i++)
      prog_m[i] = '0;
    model_tt  = '0;
    model_bit = 1'b0;
    applyStimulus("post_reset", 1'b1, 7'd0, 1, 1'b0, 1'b0);
    checkOutput("post_reset_zero", bus.tt, 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
